rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one resource (bus or functional unit) between requesters.
- The 2-bit winner index drives a 2-to-4 decoder stage to produce the one-hot grant vector.
- It adds sequencing around the decode: registered grants, a hold-until-release handshake, a rotating priority pointer and an optional hold-time timeout.
- It is the controller that owns the 2-to-4 select path in datapaths with four clients.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] high while requester i wants the resource.
- done  input  1  owner release pulse; sampled only in GRANT.
- grant  output  4  registered one-hot grant; all zeros when no owner.
- grant_idx  output  2  registered index of the current or most recent owner.
- grant_valid  output  1  high when grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (synchronous, active-high; already decided): one clock; reset is synchronous and active-high. On an edge with rst=1:
  - state=IDLE, grant=4'b0000, grant_idx=2'd0, grant_valid=0, timeout=0, cnt=0.
  - last_idx=2'd3, so requester 0 has top priority after reset.
  - rst overrides all other inputs, including mid-grant: the grant drops at that edge.
- State machine has two states, IDLE and GRANT. All outputs are registered; there is no combinational path from req or done to the outputs.
- IDLE, edge with req != 0:
  - Winner = first set bit of req scanning last_idx+1, +2, +3, +4 (mod 4).
  - Next: state=GRANT, grant_idx=winner, grant=decode(winner), grant_valid=1, cnt=0.
  - Latency: req sampled at edge N gives grant visible after edge N.
- IDLE, edge with req == 0: no change. done is ignored in IDLE.
- GRANT, each edge:
  - Release condition R = done | ~req[grant_idx] | (MAX_HOLD != 0 & cnt == MAX_HOLD-1).
  - If R: grant=0, grant_valid=0, last_idx=grant_idx, state=IDLE; grant_idx keeps its value.
  - Else: cnt=cnt+1, saturating at all-ones; grant unchanged.
  - Changes to other req bits during GRANT have no effect; there is no preemption.
- timeout:
  - Set to 1 on the release edge only when the counter expiry is the sole cause, i.e. done=0 and req[grant_idx]=1.
  - Cleared on every other edge.
  - If done or a request drop coincides with expiry, timeout stays 0.
- Consequences:
  - After any release, grant is 0 for exactly one cycle before the next owner (mandatory turnaround cycle).
  - With MAX_HOLD=M and done never asserted, a continuously requesting owner holds the grant for exactly M cycles.
  - If the released owner is the only requester, it is re-granted after the 1-cycle gap.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant == decode(grant_idx) whenever grant_valid=1.

Test Plan:
1. Reset, then req=4'b0001 -> one cycle later grant=0001, grant_idx=0, grant_valid=1. Then done pulse -> grant=0000 next edge.
2. req=4'b1111 held, done pulsed on each grant's first cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (fair rotation and wrap from 3 to 0).
3. MAX_HOLD=8, req=4'b0100 held, done=0 -> grant=0100 for exactly 8 cycles; timeout=1 in the first cycle grant=0000; 1-cycle gap; re-grant 0100.
4. Owner 1 granted (req=0010), drop req[1] mid-grant -> grant=0000 next edge, timeout=0, last_idx=1. Then req=0011 -> grant=0001 (rotation skips 1).
5. MAX_HOLD=8, done asserted on the edge where cnt==7 -> release occurs, timeout stays 0.
6. rst asserted while grant=1000 -> all outputs zero after that edge. Release rst with req=4'b1001 -> grant=0001 (pointer reset to 3).

Source files
------------

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//
// Four-requester round-robin arbiter. One shared resource is handed to one
// requester at a time. The winner is chosen by scanning the request vector
// starting just after the most recent owner. The 2-bit winner index is decoded
// to a one-hot grant. The owner keeps the grant until it pulses done, drops
// its request, or has held the grant for MAX_HOLD cycles. Every release is
// followed by one idle turnaround cycle before the next grant.
//
// Parameters
//   MAX_HOLD    maximum consecutive grant cycles per owner (0 = no timeout)
//   CNT_W       hold counter width, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req[3:0]    request vector, req[i] high while requester i wants the bus
//   done        owner release pulse, only looked at while a grant is held
//   grant[3:0]  registered one-hot grant, zero when nobody owns the resource
//   grant_idx   registered index of the current or most recent owner
//   grant_valid high whenever grant is non-zero
//   timeout     one-cycle pulse when a grant is revoked purely by hold expiry
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [3:0]       grant_reg;
    logic [1:0]       grant_idx_reg;
    logic [1:0]       last_idx_reg;
    logic             grant_valid_reg;
    logic             timeout_reg;
    logic [CNT_W-1:0] cnt_reg;

    // -------------------------------------------------------------------------
    // Rotating priority scan. Candidate gi is the requester gi+1 positions
    // after the last owner; the 2-bit add wraps naturally modulo 4, so
    // candidate 3 is the last owner itself (lowest priority).
    // -------------------------------------------------------------------------
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_idx_reg + 2'(gi + 1);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest-numbered hit candidate wins; iterate from the weakest candidate
    // upward so the strongest hit overwrites last.
    logic [1:0] win_idx;

    always_comb begin
        win_idx = cand_idx[3];
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    // 2-to-4 decoder for the winner index.
    logic [3:0] win_onehot;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Release conditions while a grant is held.
    // -------------------------------------------------------------------------
    logic owner_req;
    logic hold_expired;
    logic release_now;
    logic expiry_only;

    assign owner_req = req[grant_idx_reg];

    generate
        if (MAX_HOLD != 0) begin : g_hold_limit
            // Counter starts at 0 on the grant edge, so reaching MAX_HOLD-1
            // means the grant has been visible for MAX_HOLD cycles.
            localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
            assign hold_expired = (cnt_reg == HOLD_LAST);
        end else begin : g_no_hold_limit
            assign hold_expired = 1'b0;
        end
    endgenerate

    assign release_now = done | ~owner_req | hold_expired;
    // Timeout is only reported when expiry alone forced the release.
    assign expiry_only = hold_expired & ~done & owner_req;

    // -------------------------------------------------------------------------
    // Controller: single registered FSM, all outputs come straight from flops.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 4'b0000;
            grant_idx_reg   <= 2'd0;
            grant_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
            cnt_reg         <= '0;
            last_idx_reg    <= 2'd3;   // requester 0 scans first after reset
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state_reg       <= GRANT;
                        grant_idx_reg   <= win_idx;
                        grant_reg       <= win_onehot;
                        grant_valid_reg <= 1'b1;
                        cnt_reg         <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state_reg       <= IDLE;
                        grant_reg       <= 4'b0000;
                        grant_valid_reg <= 1'b0;
                        last_idx_reg    <= grant_idx_reg;
                        timeout_reg     <= expiry_only;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    grant_reg       <= 4'b0000;
                    grant_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4
//
// Directed-vector bench for rr_arbiter4 (MAX_HOLD=8, CNT_W=4). Each vector
// applies rst/req/done across one rising edge; the hand-computed outputs
// expected after that edge go into a queue, and a monitor on the falling edge
// pops and compares them.
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    typedef struct {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       to;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(
        .MAX_HOLD(8),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    // Monitor: outputs are stable at the falling edge after each sampled edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if ({grant, grant_idx, grant_valid, timeout} !== {e.g, e.idx, e.v, e.to}) begin
                miscompares++;
                $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                         e.name, grant, grant_idx, grant_valid, timeout, e.g, e.idx, e.v, e.to);
            end else begin
                $display("vec %0d %s: grant=%b idx=%0d valid=%b timeout=%b ok",
                         vectors, e.name, grant, grant_idx, grant_valid, timeout);
            end
        end
    end

    // Apply one vector across one rising edge and queue the expected result.
    task automatic vec(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev, input logic eto, input string nm);
        exp_t e;
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        e.g = eg; e.idx = ei; e.v = ev; e.to = eto; e.name = nm;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // 1: reset, single request, done release
        vec(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset");
        vec(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "reset_overrides");
        vec(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "t1_grant0");
        vec(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, "t1_done");
        vec(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "t1_idle");

        // 2: fair rotation with all requesting, wrap 3 -> 0
        vec(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "t2_reset");
        vec(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "t2_g0");
        vec(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "t2_r0");
        vec(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0, "t2_g1");
        vec(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0, "t2_r1");
        vec(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0, "t2_g2");
        vec(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0, "t2_r2");
        vec(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0, "t2_g3");
        vec(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0, "t2_r3");
        vec(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "t2_wrap_g0");
        vec(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "t2_wrap_r0");
        vec(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "t2_done_in_idle");

        // 3: hold expiry, exactly 8 grant cycles, timeout pulse, re-grant
        vec(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "t3_hold_c0");
        for (int i = 1; i < 8; i++)
            vec(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, $sformatf("t3_hold_c%0d", i));
        vec(0, 4'b0100, 0, 4'b0000, 2'd2, 0, 1, "t3_timeout");
        vec(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "t3_regrant");
        vec(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0, "t3_done");

        // 4: request drop mid-grant, rotation skips previous owner
        vec(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "t4_g1");
        vec(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "t4_hold1");
        vec(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, "t4_drop");
        vec(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "t4_skip1_g0");
        vec(0, 4'b0011, 1, 4'b0000, 2'd0, 0, 0, "t4_r0");
        vec(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "t4_g1_again");
        vec(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0, "t4_drop2");

        // 5: done on the expiry edge -> no timeout
        vec(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "t5_g3");
        for (int i = 1; i < 8; i++)
            vec(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, $sformatf("t5_hold_c%0d", i));
        vec(0, 4'b1000, 1, 4'b0000, 2'd3, 0, 0, "t5_done_at_expiry");
        // request drop on expiry edge, plus no preemption by req[1]
        vec(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "t5_g0");
        for (int i = 1; i < 8; i++)
            vec(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, $sformatf("t5_nopreempt_c%0d", i));
        vec(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0, "t5_drop_at_expiry");

        // 6: reset mid-grant, pointer returns to 3
        vec(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "t6_g3");
        vec(1, 4'b1000, 0, 4'b0000, 2'd0, 0, 0, "t6_reset_mid_grant");
        vec(0, 4'b1001, 0, 4'b0001, 2'd0, 1, 0, "t6_g0_after_reset");
        vec(0, 4'b1001, 1, 4'b0000, 2'd0, 0, 0, "t6_r0");
        vec(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0, "t6_g3_next");

        req  = 4'b0000;
        done = 1'b0;
        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                miscompares++;
                $display("FAIL drain: %0d vectors still queued, expected 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
